// File: rtl/char_rom_msg_reveal.sv
// Multi-message character ROM for the text overlay.
// Returns one ASCII code per char cell, with frame-synchronous message
// select, a typewriter reveal of the current message and an optional blink
// once the reveal has completed.
module char_rom_msg_reveal #(
   parameter int N_MSG         = 4,
   parameter int COL_BITS      = 8,
   parameter int REVEAL_FRAMES = 2,
   parameter int BLINK_FRAMES  = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] char_xy,
   input  logic [1:0]  msg_sel,
   input  logic        frame_tick,
   input  logic        restart,
   input  logic        blink_en,
   output logic [6:0]  char_code,
   output logic        reveal_done
);

   // Each message is space-padded to 32 chars; col c lives in byte (31 - c).
   localparam logic [255:0] MSG0 = {"GAMEOVER PRESS SPACE TO RESTART", 8'h20};
   localparam logic [255:0] MSG1 = {"PRESS SPACE TO START", {12{8'h20}}};
   localparam logic [255:0] MSG2 = {"TOM WINS", {24{8'h20}}};
   localparam logic [255:0] MSG3 = {"JERRY WINS", {22{8'h20}}};

   localparam logic [15:0] RF_LAST = 16'(REVEAL_FRAMES - 1);
   localparam logic [15:0] BF_LAST = 16'(BLINK_FRAMES - 1);

   function automatic logic [5:0] msg_len(input logic [1:0] m);
      case (m)
         2'd0:    msg_len = 6'd31;
         2'd1:    msg_len = 6'd20;
         2'd2:    msg_len = 6'd8;
         default: msg_len = 6'd10;
      endcase
   endfunction

   function automatic logic [6:0] rom_char(input logic [1:0] m, input logic [4:0] c);
      case (m)
         2'd0:    rom_char = MSG0[{~c, 3'b000} +: 7];
         2'd1:    rom_char = MSG1[{~c, 3'b000} +: 7];
         2'd2:    rom_char = MSG2[{~c, 3'b000} +: 7];
         default: rom_char = MSG3[{~c, 3'b000} +: 7];
      endcase
   endfunction

   logic [1:0]          cur_msg;
   logic [5:0]          rev_cnt;
   logic [15:0]         frame_div;
   logic [15:0]         blink_div;
   logic                blink_on;
   logic                restart_pend;
   logic [1:0]          sel_eff;
   logic [5:0]          cur_len;
   logic [5:0]          sel_len;
   logic [11-COL_BITS:0] row;
   logic [COL_BITS-1:0] col;
   logic                vis;

   // Out-of-range selections fall back to message 0.
   assign sel_eff = ({30'd0, msg_sel} < N_MSG) ? msg_sel : 2'd0;
   assign cur_len = msg_len(cur_msg);
   assign sel_len = msg_len(sel_eff);
   assign row     = char_xy[11:COL_BITS];
   assign col     = char_xy[COL_BITS-1:0];
   assign vis     = (row == '0) && (int'(col) < int'(cur_len)) &&
                    (int'(col) < int'(rev_cnt)) && blink_on;

   // Animation state: advances only on frame_tick so text never tears mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_msg      <= 2'd0;
         rev_cnt      <= 6'd0;
         frame_div    <= 16'd0;
         blink_div    <= 16'd0;
         blink_on     <= 1'b1;
         reveal_done  <= 1'b0;
         restart_pend <= 1'b0;
      end else begin
         if (frame_tick) begin
            restart_pend <= 1'b0;
            if ((sel_eff != cur_msg) || restart || restart_pend) begin
               cur_msg     <= sel_eff;
               rev_cnt     <= (REVEAL_FRAMES == 0) ? sel_len : 6'd0;
               frame_div   <= 16'd0;
               blink_div   <= 16'd0;
               blink_on    <= 1'b1;
               reveal_done <= (REVEAL_FRAMES == 0);
            end else if (!reveal_done) begin
               if ((REVEAL_FRAMES == 0) || (rev_cnt >= cur_len)) begin
                  rev_cnt     <= cur_len;
                  reveal_done <= 1'b1;
               end else if (frame_div == RF_LAST) begin
                  frame_div <= 16'd0;
                  rev_cnt   <= rev_cnt + 6'd1;
                  if ((rev_cnt + 6'd1) == cur_len) reveal_done <= 1'b1;
               end else begin
                  frame_div <= frame_div + 16'd1;
               end
            end else if (blink_en) begin
               if (blink_div == BF_LAST) begin
                  blink_div <= 16'd0;
                  blink_on  <= ~blink_on;
               end else begin
                  blink_div <= blink_div + 16'd1;
               end
            end
         end else if (restart) begin
            restart_pend <= 1'b1;
         end
         // Blink disabled forces text visible regardless of frame timing.
         if (!blink_en) begin
            blink_on  <= 1'b1;
            blink_div <= 16'd0;
         end
      end
   end

   // Registered lookup from the pre-update state; one clock of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) char_code <= 7'h20;
      else        char_code <= vis ? rom_char(cur_msg, col[4:0]) : 7'h20;
   end

endmodule

// File: tb/tb_char_rom_msg_reveal.sv
// Self-checking bench for char_rom_msg_reveal: directed steps followed by a
// randomized phase, all compared against a frame-count reference model.
module tb_char_rom_msg_reveal;

   localparam int RF = 2;
   localparam int BF = 30;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] char_xy = 12'h000;
   logic [1:0]  msg_sel = 2'd0;
   logic        frame_tick = 1'b0;
   logic        restart = 1'b0;
   logic        blink_en = 1'b0;
   logic [6:0]  char_code;
   logic        reveal_done;

   int checks = 0;
   int errors = 0;

   string msgs [4] = '{"GAMEOVER PRESS SPACE TO RESTART", "PRESS SPACE TO START",
                       "TOM WINS", "JERRY WINS"};

   // Reference model: message index, reveal frames elapsed, blink frames elapsed.
   int m_msg = 0;
   int m_frames = 0;
   int m_bframes = 0;
   bit m_pend = 1'b0;

   logic [1:0] sel_v = 2'd0;
   bit         ben_v = 1'b0;

   always #5 clk = ~clk;

   char_rom_msg_reveal #(
      .N_MSG(4), .COL_BITS(8), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .char_xy(char_xy), .msg_sel(msg_sel),
      .frame_tick(frame_tick), .restart(restart), .blink_en(blink_en),
      .char_code(char_code), .reveal_done(reveal_done)
   );

   function automatic int m_rev();
      int len;
      int r;
      len = msgs[m_msg].len();
      r = m_frames / RF;
      return (r > len) ? len : r;
   endfunction

   function automatic bit m_done();
      return m_rev() == msgs[m_msg].len();
   endfunction

   function automatic logic [6:0] m_char(input logic [11:0] xy);
      int  col;
      bit  shown;
      byte b;
      col = int'(xy[7:0]);
      shown = ((m_bframes / BF) % 2) == 0;
      if (xy[11:8] == 4'd0 && col < msgs[m_msg].len() && col < m_rev() && shown) begin
         b = msgs[m_msg][col];
         return b[6:0];
      end
      return 7'h20;
   endfunction

   function automatic logic [11:0] rand_xy();
      logic [11:0] xy;
      xy = 12'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) xy = xy | 12'h100;
      return xy;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit tk, input bit rs);
      if (tk) begin
         if (int'(sel_v) != m_msg || rs || m_pend) begin
            m_msg = int'(sel_v);
            m_frames = 0;
            m_bframes = 0;
         end else if (!m_done()) begin
            m_frames++;
         end else if (ben_v) begin
            m_bframes++;
         end
         m_pend = 1'b0;
      end else if (rs) begin
         m_pend = 1'b1;
      end
      if (!ben_v) m_bframes = 0;
   endtask

   task automatic model_reset();
      m_msg = 0;
      m_frames = 0;
      m_bframes = 0;
      m_pend = 1'b0;
   endtask

   task automatic cyc(input logic [11:0] xy, input bit tk, input bit rs);
      logic [6:0] exp;
      char_xy = xy;
      frame_tick = tk;
      restart = rs;
      msg_sel = sel_v;
      blink_en = ben_v;
      exp = m_char(xy);
      @(posedge clk);
      model_step(tk, rs);
      #1;
      check("char_code", {1'b0, char_code}, {1'b0, exp});
      check("reveal_done", {7'd0, reveal_done}, {7'd0, m_done()});
      frame_tick = 1'b0;
      restart = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(rand_xy(), 1'b1, 1'b0);
         cyc(rand_xy(), 1'b0, 1'b0);
         cyc(rand_xy(), 1'b0, 1'b0);
      end
   endtask

   task automatic look(input logic [11:0] xy, input logic [6:0] expc, input string tag);
      cyc(xy, 1'b0, 1'b0);
      check(tag, {1'b0, char_code}, {1'b0, expc});
   endtask

   initial begin
      // Power-on reset, checked asynchronously before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_code", {1'b0, char_code}, 8'h20);
      check("rst_done", {7'd0, reveal_done}, 8'h00);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      look(12'h000, 7'h20, "post_rst_x000");
      look(12'h005, 7'h20, "post_rst_x005");
      look(12'h123, 7'h20, "post_rst_x123");

      // Reveal of message 0.
      sel_v = 2'd0;
      frames(4);
      look(12'h000, 7'h47, "rev4_G");
      look(12'h001, 7'h41, "rev4_A");
      look(12'h002, 7'h20, "rev4_hidden");
      frames(58);
      check("done62", {7'd0, reveal_done}, 8'h01);
      look(12'h01E, 7'h54, "rev62_T");

      // Bounds on message 0.
      look(12'h100, 7'h20, "bound_row1");
      look(12'h01F, 7'h20, "bound_x01F");
      look(12'h0FF, 7'h20, "bound_x0FF");

      // Restart pulse between ticks is held until the next frame_tick.
      cyc(rand_xy(), 1'b0, 1'b1);
      cyc(rand_xy(), 1'b0, 1'b0);
      look(12'h000, 7'h47, "pend_hold_G");
      frames(1);
      look(12'h000, 7'h20, "restart_clear");

      // Switch to message 2 mid-reveal.
      frames(6);
      sel_v = 2'd2;
      frames(1);
      look(12'h000, 7'h20, "switch_t0");
      frames(1);
      look(12'h000, 7'h20, "switch_t1");
      frames(1);
      look(12'h000, 7'h54, "switch_t2_T");
      frames(14);
      check("done_msg2", {7'd0, reveal_done}, 8'h01);

      // Blink after reveal completes.
      ben_v = 1'b1;
      frames(30);
      look(12'h000, 7'h20, "blink_off");
      frames(30);
      look(12'h000, 7'h54, "blink_on");
      frames(30);
      look(12'h000, 7'h20, "blink_off2");
      ben_v = 1'b0;
      cyc(12'h000, 1'b0, 1'b0);
      look(12'h000, 7'h54, "blink_drop");

      // Message 3.
      sel_v = 2'd3;
      frames(21);
      check("done_msg3", {7'd0, reveal_done}, 8'h01);
      look(12'h009, 7'h53, "msg3_S");

      // Asynchronous reset mid-frame.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_code", {1'b0, char_code}, 8'h20);
      check("mid_rst_done", {7'd0, reveal_done}, 8'h00);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      look(12'h009, 7'h20, "post_mid_rst");

      // Randomized phase.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) sel_v = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) ben_v = ($urandom_range(0, 1) == 1);
         cyc(rand_xy(), ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
